mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory stage of the pipelined 32-bit core, directly downstream of the execute stage.
- Contains the EX/MEM pipeline register and a request/acknowledge FSM for a variable-latency data memory.
- Contains the MEM/WB pipeline register feeding writeback.
- Stalls upstream stages while a load or store is outstanding; reports misaligned and timed-out accesses.

Parameters:
- WIDTH, 32, datapath/address width.
- REGW, 4, destination register index width.
- TIMEOUT, 15, max cycles to wait for mem_ack before aborting (1..255).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ALUResultE  in  WIDTH  execute result / memory address.
- WriteDataE  in  WIDTH  store data (RD2 from execute).
- WA3E  in  REGW  destination register.
- RegWE  in  1  register write enable from execute (already condition-qualified).
- MemWE  in  1  store enable from execute (already condition-qualified).
- MemtoRegE  in  1  instruction is a load.
- mem_req  out  1  data memory request.
- mem_we  out  1  request is a write.
- mem_addr  out  WIDTH  word address.
- mem_wdata  out  WIDTH  store data.
- mem_rdata  in  WIDTH  load data, valid with mem_ack.
- mem_ack  in  1  memory completes the current request this cycle.
- StallM  out  1  freeze PC/IF/ID/EX registers.
- ReadDataW  out  WIDTH  loaded data.
- ALUOutW  out  WIDTH  ALU result forwarded to writeback.
- WA3W  out  REGW  destination register.
- RegWriteW  out  1  writeback enable.
- MemtoRegW  out  1  writeback selects ReadDataW.
- mem_err  out  1  sticky error flag.

Behaviour:
- Reset (rst=0, async):
  - All M and W registers clear to 0; FSM in IDLE; timeout counter 0; mem_err 0.
  - All outputs 0, including StallM and mem_req.
- EX/MEM register:
  - Loads the *E inputs on each rising edge when StallM=0.
  - Holds its contents when StallM=1.
- Access classification:
  - accessM = MemWM | MemtoRegM.
  - misalignM = accessM & (ALUResultM[1:0] != 0).
- Misaligned access:
  - No request issued, no stall.
  - mem_err sets.
  - The instruction enters MEM/WB with RegWriteW=0.
- FSM IDLE (a valid access is accessM & !misalignM):
  - mem_req=1 combinationally.
  - If mem_ack is also 1: zero-wait completion, StallM=0, remain in IDLE.
  - Otherwise StallM=1 and go to WAIT with the counter at 1.
- FSM WAIT:
  - mem_req=1; mem_we, mem_addr and mem_wdata held stable from the M register.
  - On mem_ack: completion, StallM=0, go to IDLE.
  - Else if counter==TIMEOUT: abort. mem_req drops next cycle, mem_err sets, StallM=0 this cycle, the instruction retires with RegWriteW=0, go to IDLE.
  - Else: counter increments, StallM=1.
- Request field mapping:
  - mem_we = MemWM.
  - mem_addr = ALUResultM.
  - mem_wdata = WriteDataM.
  - All three drive 0 when mem_req=0.
- MEM/WB register:
  - Loads when StallM=0; ReadDataW captures mem_rdata on load completion, otherwise 0.
  - When StallM=1, loads a bubble (RegWriteW=0, MemtoRegW=0) so writeback never repeats.
- Non-access instructions pass EX/MEM to MEM/WB with one cycle latency and no stall.
- Completed accesses add exactly the number of wait cycles.
- mem_ack seen in IDLE with no valid access is ignored.
- A store retires with RegWriteW = RegWM (normally 0).
- mem_err clears only on reset.
- Reset mid-WAIT: request dropped immediately (async); no completion is reported.

Test Plan:
- Reset check: rst=0 mid-stream, then release → all outputs 0, state IDLE; a non-access instruction (RegWE=1, WA3E=3, ALUResultE=0x10) appears on W two cycles after release with ALUOutW=0x10, RegWriteW=1.
- Zero-wait load: load addr 0x100, mem_ack=1 same cycle with mem_rdata=0xDEADBEEF → StallM never 1; next cycle ReadDataW=0xDEADBEEF, MemtoRegW=1, RegWriteW=1.
- 3-wait store: store addr 0x40 data 0x55, ack on 4th request cycle → StallM=1 for exactly 3 cycles; mem_addr, mem_wdata and mem_we stable throughout; W gets bubbles for 3 cycles, then the store retires with RegWriteW=0; a following ALU instruction is not lost.
- Timeout: load with ack never asserted, TIMEOUT=15 → mem_req high for 16 cycles, then low; mem_err=1 thereafter; load retires with RegWriteW=0.
- Misaligned: load addr 0x102 → mem_req stays 0, no stall, mem_err=1, RegWriteW=0.
- Back-to-back loads with 1 wait each, reset asserted during the second WAIT → mem_req drops within the reset cycle; after release no spurious writeback occurs.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage (master) and
// a variable-latency data memory (slave).
interface mem_stage_if #(
    parameter int WIDTH = 32
);
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: EX/MEM register, request/ack FSM with timeout for a
// variable-latency data memory, and the MEM/WB register.
module mem_stage #(
    parameter int WIDTH   = 32,
    parameter int REGW    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ALUResultE,
    input  logic [WIDTH-1:0] WriteDataE,
    input  logic [REGW-1:0]  WA3E,
    input  logic             RegWE,
    input  logic             MemWE,
    input  logic             MemtoRegE,
    mem_stage_if.master      mem,
    output logic             StallM,
    output logic [WIDTH-1:0] ReadDataW,
    output logic [WIDTH-1:0] ALUOutW,
    output logic [REGW-1:0]  WA3W,
    output logic             RegWriteW,
    output logic             MemtoRegW,
    output logic             mem_err
);
    localparam logic [7:0] TMO = 8'(TIMEOUT);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t           state, state_nx;
    logic [7:0]       cnt, cnt_nx;
    logic [WIDTH-1:0] ALUResultM, WriteDataM;
    logic [REGW-1:0]  WA3M;
    logic             RegWM, MemWM, MemtoRegM;
    logic             accessM, misalignM, validM;
    logic             req, done, abort;

    assign accessM   = MemWM | MemtoRegM;
    assign misalignM = accessM & (ALUResultM[1:0] != 2'b00);
    assign validM    = accessM & ~misalignM;

    // ---- EX/MEM boundary ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ALUResultM <= '0;
            WriteDataM <= '0;
            WA3M       <= '0;
            RegWM      <= 1'b0;
            MemWM      <= 1'b0;
            MemtoRegM  <= 1'b0;
        end else if (!StallM) begin
            ALUResultM <= ALUResultE;
            WriteDataM <= WriteDataE;
            WA3M       <= WA3E;
            RegWM      <= RegWE;
            MemWM      <= MemWE;
            MemtoRegM  <= MemtoRegE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        req      = 1'b0;
        StallM   = 1'b0;
        done     = 1'b0;
        abort    = 1'b0;
        case (state)
            IDLE: begin
                if (validM) begin
                    req = 1'b1;
                    if (mem.mem_ack) begin
                        done = 1'b1;
                    end else begin
                        StallM   = 1'b1;
                        state_nx = WAIT;
                        cnt_nx   = 8'd1;
                    end
                end
            end
            WAIT: begin
                req = 1'b1;
                if (mem.mem_ack) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == TMO) begin
                    // Give up: let the instruction retire without a writeback.
                    abort    = 1'b1;
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    StallM = 1'b1;
                    cnt_nx = cnt + 8'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign mem.mem_req   = req;
    assign mem.mem_we    = req & MemWM;
    assign mem.mem_addr  = req ? ALUResultM : '0;
    assign mem.mem_wdata = req ? WriteDataM : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            mem_err <= 1'b0;
        else if (misalignM | abort)
            mem_err <= 1'b1;
    end

    // ---- MEM/WB boundary ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ReadDataW <= '0;
            ALUOutW   <= '0;
            WA3W      <= '0;
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
        end else if (StallM) begin
            ReadDataW <= '0;
            ALUOutW   <= '0;
            WA3W      <= '0;
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
        end else begin
            ReadDataW <= (done & MemtoRegM) ? mem.mem_rdata : '0;
            ALUOutW   <= ALUResultM;
            WA3W      <= WA3M;
            RegWriteW <= RegWM & ~misalignM & ~abort;
            MemtoRegW <= MemtoRegM;
        end
    end
endmodule
